// File: rtl/pru_cmd_pkg.sv
// Shared definitions for the PRU command word protocol: field positions,
// the host-side command record, encoder FSM states and word packing helpers.
package pru_cmd_pkg;

  // Word 1 field positions
  localparam int ROW_LSB   = 0;
  localparam int COL_LSB   = 9;
  localparam int COLOR_LSB = 19;
  localparam int SHAPE_LSB = 21;
  localparam int IMM_BIT   = 22;  // shape[1]: word 2 carries a bitmap address

  // Word 2 (shape form) field positions
  localparam int HEIGHT_LSB = 0;
  localparam int WIDTH_LSB  = 9;
  localparam int SUB_BIT    = 19;
  localparam int CLOAD_BIT  = 20;

  typedef struct packed {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [1:0]  color;
    logic [1:0]  shape;
    logic [9:0]  width;
    logic [8:0]  height_radius;
    logic        subtract;
    logic        color_load;
    logic [31:0] bitmap_address;
  } pru_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } enc_state_t;

  function automatic logic [31:0] pack_word1(input pru_cmd_t c);
    logic [31:0] w;
    w = '0;
    w[ROW_LSB   +: 9]  = c.row;
    w[COL_LSB   +: 10] = c.col;
    w[COLOR_LSB +: 2]  = c.color;
    w[SHAPE_LSB +: 2]  = c.shape;
    return w;
  endfunction

  function automatic logic [31:0] pack_word2(input pru_cmd_t c);
    logic [31:0] w;
    w = '0;
    if (c.shape[IMM_BIT - SHAPE_LSB]) begin
      w = c.bitmap_address;
    end else begin
      w[HEIGHT_LSB +: 9]  = c.height_radius;
      w[WIDTH_LSB  +: 10] = c.width;
      w[SUB_BIT]          = c.subtract;
      w[CLOAD_BIT]        = c.color_load;
    end
    return w;
  endfunction

endpackage

// File: rtl/pru_cmd_fifo.sv
// Small synchronous FIFO of complete commands between the producer port and
// the serializer. DEPTH must be a power of two so the pointers wrap freely.
module pru_cmd_fifo
  import pru_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  pru_cmd_t wr_data,
  input  logic     pop,
  output pru_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  pru_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array write.
  // NOTE: the storage has no reset; entries are only read after being written, and count guards that.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pru_cmd_encoder.sv
// Host-side transmitter: buffers draw commands and serializes each one into
// the two-word write/data/ack sequence the PRU preprocessor consumes.
module pru_cmd_encoder
  import pru_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_row,
  input  logic [9:0]  cmd_col,
  input  logic [1:0]  cmd_color,
  input  logic [1:0]  cmd_shape,
  input  logic [9:0]  cmd_width,
  input  logic [8:0]  cmd_height_radius,
  input  logic        cmd_subtract,
  input  logic        cmd_color_load,
  input  logic [31:0] cmd_bitmap_address,
  output logic        write,
  output logic [31:0] data,
  input  logic        ack,
  output logic        busy,
  output logic        cmd_done,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  enc_state_t       state;
  pru_cmd_t         in_cmd;
  pru_cmd_t         head_cmd;
  pru_cmd_t         hold_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             accept;
  logic [CNT_W-1:0] stall_cnt;

  assign in_cmd = '{row:            cmd_row,
                    col:            cmd_col,
                    color:          cmd_color,
                    shape:          cmd_shape,
                    width:          cmd_width,
                    height_radius:  cmd_height_radius,
                    subtract:       cmd_subtract,
                    color_load:     cmd_color_load,
                    bitmap_address: cmd_bitmap_address};

  // NOTE: ready comes from the registered FIFO occupancy only, so a producer never sees it combinationally follow a pop.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // ack is only meaningful while a word is offered; gating with write keeps a floating ack out.
  assign accept    = write && ack;
  assign pop       = !fifo_empty && ((state == IDLE) || (state == SEND2 && accept));
  assign busy      = !fifo_empty || (state != IDLE);

  pru_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_cmd),
    .pop     (pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serializer FSM: all handshake outputs are registered so data/write never follow ack combinationally.
  // NOTE: non-blocking assignments throughout so every branch sees the pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      write    <= 1'b0;
      data     <= '0;
      cmd_done <= 1'b0;
      hold_cmd <= '0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            hold_cmd <= head_cmd;
            data     <= pack_word1(head_cmd);
            write    <= 1'b1;
            state    <= SEND1;
          end
        end
        SEND1: begin
          if (accept) begin
            data  <= pack_word2(hold_cmd);
            state <= SEND2;
          end
        end
        SEND2: begin
          if (accept) begin
            cmd_done <= 1'b1;
            if (!fifo_empty) begin
              hold_cmd <= head_cmd;
              data     <= pack_word1(head_cmd);
              state    <= SEND1;
            end else begin
              write <= 1'b0;
              data  <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          write <= 1'b0;
          data  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake watchdog: counts unacknowledged cycles and latches a sticky error; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        stall_cnt <= '0;
      end else if (write && stall_cnt != CNT_LAST) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (write && !ack && stall_cnt == CNT_LAST) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pru_cmd_encoder.sv
// Self-checking bench for pru_cmd_encoder: a scoreboard of expected words is
// filled as commands are accepted and drained by a monitor as words are acked.
module tb_pru_cmd_encoder;
  import pru_cmd_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_row = '0;
  logic [9:0]  cmd_col = '0;
  logic [1:0]  cmd_color = '0;
  logic [1:0]  cmd_shape = '0;
  logic [9:0]  cmd_width = '0;
  logic [8:0]  cmd_height_radius = '0;
  logic        cmd_subtract = 1'b0;
  logic        cmd_color_load = 1'b0;
  logic [31:0] cmd_bitmap_address = '0;
  logic        write;
  logic [31:0] data;
  logic        ack = 1'b0;
  logic        busy;
  logic        cmd_done;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  pru_cmd_encoder #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_row            (cmd_row),
    .cmd_col            (cmd_col),
    .cmd_color          (cmd_color),
    .cmd_shape          (cmd_shape),
    .cmd_width          (cmd_width),
    .cmd_height_radius  (cmd_height_radius),
    .cmd_subtract       (cmd_subtract),
    .cmd_color_load     (cmd_color_load),
    .cmd_bitmap_address (cmd_bitmap_address),
    .write              (write),
    .data               (data),
    .ack                (ack),
    .busy               (busy),
    .cmd_done           (cmd_done),
    .timeout_err        (timeout_err),
    .err_clr            (err_clr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  int          word_idx = 0;
  logic        done_expect = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_write = 1'b0;
  logic [31:0] prev_data = '0;
  int          write_cycles = 0;
  int          write_runs = 0;
  int          done_count = 0;

  // Reference packing, written directly from the word layouts.
  function automatic logic [31:0] m_word1(input pru_cmd_t c);
    return {9'd0, c.shape, c.color, c.col, c.row};
  endfunction

  function automatic logic [31:0] m_word2(input pru_cmd_t c);
    if (c.shape[1]) return c.bitmap_address;
    return {11'd0, c.color_load, c.subtract, c.width, c.height_radius};
  endfunction

  function automatic pru_cmd_t rand_cmd();
    pru_cmd_t c;
    c.row            = 9'($urandom);
    c.col            = 10'($urandom);
    c.color          = 2'($urandom);
    c.shape          = 2'($urandom);
    c.width          = 10'($urandom);
    c.height_radius  = 9'($urandom);
    c.subtract       = 1'($urandom);
    c.color_load     = 1'($urandom);
    c.bitmap_address = $urandom;
    return c;
  endfunction

  // Monitor: pops the scoreboard on every accepted word, checks hold-stability and cmd_done timing.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      word_idx    = 0;
      done_expect = 1'b0;
      prev_stall  = 1'b0;
      prev_write  = 1'b0;
      prev_data   = '0;
    end else begin
      if (cmd_done || done_expect) begin
        n_cmp++;
        if (cmd_done !== done_expect) begin
          n_bad++;
          $display("FAIL cmd_done_timing @%0t: got %0b want %0b", $time, cmd_done, done_expect);
        end
      end
      if (cmd_done === 1'b1) done_count++;
      if (prev_stall) begin
        n_cmp++;
        if (write !== 1'b1 || data !== prev_data) begin
          n_bad++;
          $display("FAIL hold_stable @%0t: got write=%0b data=%08h want write=1 data=%08h",
                   $time, write, data, prev_data);
        end
      end
      if (!write && prev_write) begin
        n_cmp++;
        if (data !== 32'd0) begin
          n_bad++;
          $display("FAIL idle_data @%0t: got %08h want 00000000", $time, data);
        end
      end
      if (write && !prev_write) write_runs++;
      if (write) write_cycles++;
      done_expect = 1'b0;
      if (write && ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word @%0t: got %08h want no word", $time, data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL word_data @%0t: got %08h want %08h", $time, data, e);
          end
        end
        done_expect = (word_idx == 1);
        word_idx    = 1 - word_idx;
      end
      prev_stall = write && !ack;
      prev_data  = data;
      prev_write = write;
    end
  end

  task automatic drive_cmd(input pru_cmd_t c);
    cmd_row            = c.row;
    cmd_col            = c.col;
    cmd_color          = c.color;
    cmd_shape          = c.shape;
    cmd_width          = c.width;
    cmd_height_radius  = c.height_radius;
    cmd_subtract       = c.subtract;
    cmd_color_load     = c.color_load;
    cmd_bitmap_address = c.bitmap_address;
  endtask

  // Offers one command; on acceptance queues its expected words. Starts and ends just after a rising edge.
  task automatic push_cmd(input pru_cmd_t c, input logic [31:0] w1, input logic [31:0] w2);
    bit accepted;
    accepted = 0;
    drive_cmd(c);
    cmd_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (accepted) begin
      exp_q.push_back(w1);
      exp_q.push_back(w2);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got cmd_ready=0 for 64 cycles want 1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_model(input pru_cmd_t c);
    push_cmd(c, m_word1(c), m_word2(c));
  endtask

  // Waits for the encoder to go idle with nothing outstanding.
  task automatic wait_drain(input string name);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy && !write && exp_q.size() == 0) break;
    end
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got busy=%0b pending=%0d want busy=0 pending=0",
               name, busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %0b want 0", write); end
    n_cmp++; if (data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %08h want 0", data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
    n_cmp++; if (cmd_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", cmd_done); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", timeout_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    ack = 1'b1;  // ack while idle must be ignored
    repeat (4) @(negedge clk);
    n_cmp++; if (write !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack_ignored: got write=%0b busy=%0b want 0 0", write, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shape();
    pru_cmd_t c;
    int d0, r0, w0;
    d0 = done_count; r0 = write_runs; w0 = write_cycles;
    c = '0;
    c.row = 9'd5; c.col = 10'd10; c.color = 2'd2; c.shape = 2'b01;
    c.height_radius = 9'd20; c.width = 10'd30; c.subtract = 1'b1; c.color_load = 1'b0;
    c.bitmap_address = 32'h1234_5678;
    ack = 1'b1;
    push_cmd(c, 32'h0030_1405, 32'h0008_3C14);
    wait_drain("shape");
    n_cmp++; if (done_count - d0 != 1) begin n_bad++; $display("FAIL shape_done: got %0d want 1", done_count - d0); end
    n_cmp++; if (write_cycles - w0 != 2 || write_runs - r0 != 1) begin
      n_bad++; $display("FAIL shape_write_cycles: got cycles=%0d runs=%0d want 2 1", write_cycles - w0, write_runs - r0);
    end
  endtask

  task automatic test_immediate();
    pru_cmd_t c;
    int d0;
    d0 = done_count;
    c = '0;
    c.shape = 2'b10; c.bitmap_address = 32'hDEAD_BEEF;
    c.width = 10'h3FF; c.height_radius = 9'h1AB; c.subtract = 1'b1; c.color_load = 1'b1;
    ack = 1'b1;
    push_cmd(c, 32'h0040_0000, 32'hDEAD_BEEF);
    wait_drain("immediate");
    n_cmp++; if (done_count - d0 != 1) begin n_bad++; $display("FAIL imm_done: got %0d want 1", done_count - d0); end
  endtask

  task automatic test_back_to_back();
    int d0, r0, w0;
    d0 = done_count; r0 = write_runs; w0 = write_cycles;
    ack = 1'b1;
    for (int i = 0; i < 4; i++) push_model(rand_cmd());
    wait_drain("b2b");
    n_cmp++; if (write_cycles - w0 != 8 || write_runs - r0 != 1) begin
      n_bad++; $display("FAIL b2b_contiguous: got cycles=%0d runs=%0d want 8 1", write_cycles - w0, write_runs - r0);
    end
    n_cmp++; if (done_count - d0 != 4) begin n_bad++; $display("FAIL b2b_done: got %0d want 4", done_count - d0); end
  endtask

  task automatic test_full();
    pru_cmd_t c;
    int accepted, d0;
    logic saw_low;
    accepted = 0; saw_low = 1'b0; d0 = done_count;
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = rand_cmd();
      drive_cmd(c);
      cmd_valid = 1'b1;
      @(negedge clk);
      if (!cmd_ready) begin
        saw_low = 1'b1;
        break;
      end
      exp_q.push_back(m_word1(c));
      exp_q.push_back(m_word2(c));
      accepted++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++; if (!saw_low || accepted != FIFO_DEPTH + 1) begin
      n_bad++; $display("FAIL full_ready_drop: got accepted=%0d ready_low=%0b want %0d 1", accepted, saw_low, FIFO_DEPTH + 1);
    end
    ack = 1'b1;
    wait_drain("full");
    n_cmp++; if (done_count - d0 != accepted) begin n_bad++; $display("FAIL full_done: got %0d want %0d", done_count - d0, accepted); end
  endtask

  task automatic test_ack_delay();
    int d0, r0;
    d0 = done_count; r0 = write_runs;
    ack = 1'b0;
    push_model(rand_cmd());
    push_model(rand_cmd());
    for (int w = 0; w < 4; w++) begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (write) begin seen = 1; break; end
      end
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL delay_word_missing: got write=0 for word %0d want 1", w);
        break;
      end
      repeat (3) @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL delay_no_timeout: got %0b want 0", timeout_err); end
    wait_drain("delay");
    n_cmp++; if (done_count - d0 != 2 || write_runs - r0 != 1) begin
      n_bad++; $display("FAIL delay_done: got done=%0d runs=%0d want 2 1", done_count - d0, write_runs - r0);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    seen = 0;
    ack = 1'b0;
    push_model(rand_cmd());
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (write) begin seen = 1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL timeout_write_rise: got 0 want 1"); end
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      @(negedge clk);
      if (k == ACK_TIMEOUT - 1) begin
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %0b want 0", timeout_err); end
      end
    end
    n_cmp++; if (timeout_err !== 1'b1 || write !== 1'b1) begin
      n_bad++; $display("FAIL timeout_set: got err=%0b write=%0b want 1 1", timeout_err, write);
    end
    @(posedge clk); #1;
    err_clr = 1'b1;  // coincides with a still-stalled word: set must win
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_set_wins: got %0b want 1", timeout_err); end
    @(posedge clk); #1;
    err_clr = 1'b0;
    ack = 1'b1;
    wait_drain("timeout");
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %0b want 1", timeout_err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %0b want 0", timeout_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    int r0;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) push_model(rand_cmd());
    ack = 1'b1;  // accept word 1 of the first command only
    @(posedge clk); #1;
    ack = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (write !== 1'b0 || data !== 32'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got write=%0b data=%08h want 0 0", write, data);
    end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_flush: got busy=%0b ready=%0b want 0 1", busy, cmd_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r0 = write_runs;
    ack = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (write_runs != r0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_stale: got runs=%0d busy=%0b want 0 0", write_runs - r0, busy);
    end
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_shape();
    test_immediate();
    test_back_to_back();
    test_full();
    test_ack_delay();
    test_timeout();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
